// File: rtl/pf_ddr4_c0_ddrphy_blk_iod_rx_lane_train.sv
// One DDR4 PHY receive lane: trains the IOD delay line and 2-bit word slip, then streams aligned data.
// Optional mismatch counter (ERR_CNT) is built when PF_DDR4_RX_LANE_ERR_CNT_EN is defined.
module pf_ddr4_c0_ddrphy_blk_iod_rx_lane_train #(
  parameter logic [3:0] TRAIN_PATTERN = 4'b0011,
  parameter int         SETTLE_CYC    = 8,
  parameter int         CMP_CYC       = 16,
  parameter int         MIN_WINDOW    = 4,
  parameter logic [7:0] MAX_TAP       = 8'd127
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       TRAIN_START,
  input  logic [3:0] RX_DATA_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic       DELAY_LINE_LOAD_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic [3:0] RX_DATA_ALIGNED,
  output logic       RX_DATA_VALID,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [1:0] BIT_SLIP,
  output logic [7:0] TAP_CENTER,
  output logic [7:0] WINDOW_WIDTH
`ifdef PF_DDR4_RX_LANE_ERR_CNT_EN
  ,
  output logic [15:0] ERR_CNT
`endif
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] CMP_LAST    = 8'(CMP_CYC - 1);
  localparam logic [7:0] MIN_W       = 8'(MIN_WINDOW);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_MOVE, S_BACK, S_DONE, S_FAIL
  } state_t;

  state_t      state;
  logic [3:0]  prev, match, rot_eq, aligned_next;
  logic [7:0]  window;
  logic [7:0]  tap, cnt, centre, win_start, win_width;
  logic [1:0]  win_rot, pass_rot, slip_sel;
  logic        win_open, back_phase, pass, exhausted, start_req, back_done;
  logic        close_accept, exh_accept, accept, n_open;
  logic [7:0]  n_start, n_width, acc_start, acc_width, acc_centre;
  logic [1:0]  n_rot, acc_rot;

  // Rotation compare, tap verdict and output word selection.
  always_comb begin
    window = {RX_DATA_0, prev};
    for (int r = 0; r < 4; r++) begin
      rot_eq[r] = (window[r +: 4] == TRAIN_PATTERN);
    end
    pass = |match;
    if (match[0]) begin
      pass_rot = 2'd0;
    end else if (match[1]) begin
      pass_rot = 2'd1;
    end else if (match[2]) begin
      pass_rot = 2'd2;
    end else begin
      pass_rot = 2'd3;
    end
    exhausted = (tap == MAX_TAP) || DELAY_LINE_OUT_OF_RANGE_0;
    start_req = TRAIN_START && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
    back_done = (state == S_BACK) && (tap == centre);
    // The locked rotation is used already on the edge entering DONE so the first valid word is aligned.
    if (back_done) begin
      slip_sel = win_rot;
    end else begin
      slip_sel = BIT_SLIP;
    end
    aligned_next = window[slip_sel +: 4];
  end

  // Passing-window bookkeeping for the tap currently being evaluated.
  always_comb begin
    n_open       = win_open;
    n_start      = win_start;
    n_width      = win_width;
    n_rot        = win_rot;
    close_accept = 1'b0;
    if (win_open && pass && (pass_rot == win_rot)) begin
      n_width = win_width + 8'd1;
    end else if (win_open) begin
      close_accept = (win_width >= MIN_W);
      n_open       = pass;
      n_start      = tap;
      n_rot        = pass_rot;
      n_width      = 8'd1;
    end else if (pass) begin
      n_open  = 1'b1;
      n_start = tap;
      n_rot   = pass_rot;
      n_width = 8'd1;
    end else begin
      n_open = 1'b0;
    end
    exh_accept = exhausted && n_open && (n_width >= MIN_W);
    accept     = close_accept || exh_accept;
    if (close_accept) begin
      acc_start = win_start;
      acc_width = win_width;
      acc_rot   = win_rot;
    end else if (exh_accept) begin
      acc_start = n_start;
      acc_width = n_width;
      acc_rot   = n_rot;
    end else begin
      acc_start = win_start;
      acc_width = win_width;
      acc_rot   = win_rot;
    end
    acc_centre = acc_start + ((acc_width - 8'd1) >> 1);
  end

  // Training FSM, delay-line controls, status and aligned data.
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state                  <= S_IDLE;
      prev                   <= 4'd0;
      match                  <= 4'd0;
      tap                    <= 8'd0;
      cnt                    <= 8'd0;
      centre                 <= 8'd0;
      win_open               <= 1'b0;
      win_start              <= 8'd0;
      win_width              <= 8'd0;
      win_rot                <= 2'd0;
      back_phase             <= 1'b0;
      DELAY_LINE_LOAD_0      <= 1'b0;
      DELAY_LINE_MOVE_0      <= 1'b0;
      DELAY_LINE_DIRECTION_0 <= 1'b0;
      RX_DATA_ALIGNED        <= 4'd0;
      RX_DATA_VALID          <= 1'b0;
      TRAIN_BUSY             <= 1'b0;
      TRAIN_DONE             <= 1'b0;
      TRAIN_FAIL             <= 1'b0;
      BIT_SLIP               <= 2'd0;
      TAP_CENTER             <= 8'd0;
      WINDOW_WIDTH           <= 8'd0;
`ifdef PF_DDR4_RX_LANE_ERR_CNT_EN
      ERR_CNT                <= 16'd0;
`endif
    end else begin
      prev              <= RX_DATA_0;
      RX_DATA_ALIGNED   <= aligned_next;
      DELAY_LINE_LOAD_0 <= 1'b0;
      DELAY_LINE_MOVE_0 <= 1'b0;
      if (start_req) begin
        DELAY_LINE_LOAD_0 <= 1'b1;
        TRAIN_BUSY        <= 1'b1;
        TRAIN_DONE        <= 1'b0;
        TRAIN_FAIL        <= 1'b0;
        RX_DATA_VALID     <= 1'b0;
        tap               <= 8'd0;
        win_open          <= 1'b0;
        win_width         <= 8'd0;
        state             <= S_LOAD;
`ifdef PF_DDR4_RX_LANE_ERR_CNT_EN
        ERR_CNT           <= 16'd0;
`endif
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_LOAD, S_MOVE: begin
            cnt   <= 8'd0;
            state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= 8'd0;
              match <= 4'hF;
              state <= S_CHECK;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_CHECK: begin
            match <= match & rot_eq;
            if (cnt == CMP_LAST) begin
              state <= S_EVAL;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_EVAL: begin
            if (accept) begin
              win_open   <= 1'b0;
              win_start  <= acc_start;
              win_width  <= acc_width;
              win_rot    <= acc_rot;
              centre     <= acc_centre;
              back_phase <= 1'b0;
              state      <= S_BACK;
            end else if (exhausted) begin
              win_open   <= 1'b0;
              TRAIN_BUSY <= 1'b0;
              TRAIN_FAIL <= 1'b1;
              state      <= S_FAIL;
            end else begin
              win_open               <= n_open;
              win_start              <= n_start;
              win_width              <= n_width;
              win_rot                <= n_rot;
              tap                    <= tap + 8'd1;
              DELAY_LINE_MOVE_0      <= 1'b1;
              DELAY_LINE_DIRECTION_0 <= 1'b1;
              state                  <= S_MOVE;
            end
          end
          // Walk back towards the centre with a MOVE pulse every other cycle.
          S_BACK: begin
            if (back_done) begin
              BIT_SLIP      <= win_rot;
              TAP_CENTER    <= tap;
              WINDOW_WIDTH  <= win_width;
              TRAIN_BUSY    <= 1'b0;
              TRAIN_DONE    <= 1'b1;
              RX_DATA_VALID <= 1'b1;
              state         <= S_DONE;
            end else if (!back_phase) begin
              DELAY_LINE_MOVE_0      <= 1'b1;
              DELAY_LINE_DIRECTION_0 <= 1'b0;
              tap                    <= tap - 8'd1;
              back_phase             <= 1'b1;
            end else begin
              back_phase <= 1'b0;
            end
          end
          S_DONE: begin
`ifdef PF_DDR4_RX_LANE_ERR_CNT_EN
            if ((RX_DATA_ALIGNED != TRAIN_PATTERN) && (ERR_CNT != 16'hFFFF)) begin
              ERR_CNT <= ERR_CNT + 16'd1;
            end
`endif
            state <= S_DONE;
          end
          S_FAIL: state <= S_FAIL;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
